// File: rtl/ddr_iod_delay_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_iod_delay_tap_ctrl_if
// Purpose  : Command/completion bundle between PHY training and the IOD
//            delay tap controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_iod_delay_tap_ctrl_if #(
  parameter int NUM_LANES = 8,
  parameter int TAP_BITS  = 7
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                CMD_VALID;
  logic                CMD_READY;
  logic [LANE_W-1:0]   CMD_LANE;
  logic [1:0]          CMD_OP;
  logic [TAP_BITS-1:0] CMD_TAP;
  logic                DONE;
  logic                ERR;

  modport master (
    output CMD_VALID, CMD_LANE, CMD_OP, CMD_TAP,
    input  CMD_READY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_LANE, CMD_OP, CMD_TAP,
    output CMD_READY, DONE, ERR
  );
endinterface
`default_nettype wire

// File: rtl/ddr_iod_delay_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_iod_delay_tap_ctrl
// Purpose  : Multi-lane IOD delay-line controller: turns LOAD/INC/DEC/SET
//            commands into spaced strobes and keeps a shadow tap per lane.
//            Optional macro DDR_TAP_OOR_STATUS_EN adds sticky per-lane
//            out-of-range status (OOR_STATUS) with OOR_CLEAR.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_iod_delay_tap_ctrl #(
  parameter  int NUM_LANES     = 8,
  parameter  int TAP_BITS      = 7,
  parameter  int MAX_TAP       = 127,
  parameter  int SETTLE_CYCLES = 4,
  localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  wire logic                 FAB_CLK,
  input  wire logic                 ARST,
  ddr_iod_delay_tap_ctrl_if.slave   cmd,
  input  wire logic [LANE_W-1:0]    RD_LANE,
  output logic      [TAP_BITS-1:0]  RD_TAP,
  output logic      [NUM_LANES-1:0] DELAY_LINE_LOAD,
  output logic      [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic      [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  input  wire logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
`ifdef DDR_TAP_OOR_STATUS_EN
  ,
  input  wire logic                 OOR_CLEAR,
  output logic      [NUM_LANES-1:0] OOR_STATUS
`endif
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LOAD   = 3'd1;
  localparam logic [2:0] c_ST_MOVE   = 3'd2;
  localparam logic [2:0] c_ST_SETTLE = 3'd3;
  localparam logic [2:0] c_ST_FIN    = 3'd4;

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_INC  = 2'b01;
  localparam logic [1:0] c_OP_DEC  = 2'b10;

  localparam logic [TAP_BITS-1:0]  c_MAX_TAP     = TAP_BITS'(MAX_TAP);
  localparam logic [TAP_BITS-1:0]  c_TAP_ONE     = TAP_BITS'(1);
  localparam logic [7:0]           c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [NUM_LANES-1:0] c_LANE0       = NUM_LANES'(1);

  logic [2:0]          state_q, state_d;
  logic [LANE_W-1:0]   lane_q,  lane_d;
  logic                dir_q,   dir_d;
  logic                err_q,   err_d;
  logic [TAP_BITS-1:0] rem_q,   rem_d;
  logic [7:0]          cnt_q,   cnt_d;
  logic [TAP_BITS-1:0] tap_q [NUM_LANES];

  logic                 w_cmd_lane_ok;
  logic                 w_lane_ok;
  logic [TAP_BITS-1:0]  w_cmd_shadow;
  logic [TAP_BITS-1:0]  w_cur_shadow;
  logic                 w_cmd_at_max;
  logic                 w_cmd_at_min;
  logic                 w_settle_last;
  logic                 w_oor_in;
  logic [NUM_LANES-1:0] w_lane_vec;
  logic                 w_tap_we;
  logic [TAP_BITS-1:0]  w_tap_wdata;

  assign w_cmd_lane_ok = (32'(cmd.CMD_LANE) < NUM_LANES);
  assign w_lane_ok     = (32'(lane_q) < NUM_LANES);
  assign w_cmd_shadow  = w_cmd_lane_ok ? tap_q[cmd.CMD_LANE] : '0;
  assign w_cur_shadow  = w_lane_ok ? tap_q[lane_q] : '0;
  assign w_cmd_at_max  = (w_cmd_shadow == c_MAX_TAP);
  assign w_cmd_at_min  = (w_cmd_shadow == '0);
  assign w_lane_vec    = w_lane_ok ? (c_LANE0 << lane_q) : '0;
  assign w_settle_last = (cnt_q == c_SETTLE_LAST);
  assign w_oor_in      = |(DELAY_LINE_OUT_OF_RANGE & w_lane_vec);
  assign RD_TAP        = (32'(RD_LANE) < NUM_LANES) ? tap_q[RD_LANE] : '0;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= c_ST_IDLE;
      lane_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      if (w_tap_we && w_lane_ok) begin
        tap_q[lane_q] <= w_tap_wdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    dir_d       = dir_q;
    err_d       = err_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    w_tap_we    = 1'b0;
    w_tap_wdata = w_cur_shadow;
    case (state_q)
      c_ST_IDLE: begin
        if (cmd.CMD_VALID) begin
          lane_d = cmd.CMD_LANE;
          err_d  = 1'b0;
          rem_d  = '0;
          dir_d  = 1'b0;
          if (!w_cmd_lane_ok) begin
            state_d = c_ST_FIN;
            err_d   = 1'b1;
          end else begin
            case (cmd.CMD_OP)
              c_OP_LOAD: state_d = c_ST_LOAD;
              c_OP_INC: begin
                dir_d = 1'b1;
                if (w_cmd_at_max) begin
                  state_d = c_ST_FIN;
                  err_d   = 1'b1;
                end else begin
                  state_d = c_ST_MOVE;
                  rem_d   = c_TAP_ONE;
                end
              end
              c_OP_DEC: begin
                if (w_cmd_at_min) begin
                  state_d = c_ST_FIN;
                  err_d   = 1'b1;
                end else begin
                  state_d = c_ST_MOVE;
                  rem_d   = c_TAP_ONE;
                end
              end
              default: begin
                // SET: reload to zero, then walk up to the clamped target
                dir_d   = 1'b1;
                state_d = c_ST_LOAD;
                if (cmd.CMD_TAP > c_MAX_TAP) begin
                  rem_d = c_MAX_TAP;
                  err_d = 1'b1;
                end else begin
                  rem_d = cmd.CMD_TAP;
                end
              end
            endcase
          end
        end
      end
      c_ST_LOAD: begin
        w_tap_we    = 1'b1;
        w_tap_wdata = '0;
        cnt_d       = '0;
        state_d     = c_ST_SETTLE;
      end
      c_ST_MOVE: begin
        w_tap_we    = 1'b1;
        w_tap_wdata = dir_q ? (w_cur_shadow + c_TAP_ONE) : (w_cur_shadow - c_TAP_ONE);
        rem_d       = rem_q - c_TAP_ONE;
        cnt_d       = '0;
        state_d     = c_ST_SETTLE;
      end
      c_ST_SETTLE: begin
        if (w_settle_last) begin
          if (w_oor_in) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = c_ST_FIN;
          end else if (rem_q != '0) begin
            state_d = c_ST_MOVE;
          end else begin
            state_d = c_ST_FIN;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      c_ST_FIN: state_d = c_ST_IDLE;
      default:  state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    cmd.CMD_READY        = (state_q == c_ST_IDLE);
    cmd.DONE             = (state_q == c_ST_FIN);
    cmd.ERR              = (state_q == c_ST_FIN) && err_q;
    DELAY_LINE_LOAD      = (state_q == c_ST_LOAD) ? w_lane_vec : '0;
    DELAY_LINE_MOVE      = (state_q == c_ST_MOVE) ? w_lane_vec : '0;
    DELAY_LINE_DIRECTION = dir_q ? w_lane_vec : '0;
  end

`ifdef DDR_TAP_OOR_STATUS_EN
  logic [NUM_LANES-1:0] oor_status_q, oor_status_d;
  logic [NUM_LANES-1:0] w_oor_set;
  logic                 w_rej_evt;
  logic                 w_abort_evt;

  assign w_rej_evt   = (state_q == c_ST_IDLE) && cmd.CMD_VALID && w_cmd_lane_ok &&
                       (((cmd.CMD_OP == c_OP_INC) && w_cmd_at_max) ||
                        ((cmd.CMD_OP == c_OP_DEC) && w_cmd_at_min));
  assign w_abort_evt = (state_q == c_ST_SETTLE) && w_settle_last && w_oor_in;
  assign w_oor_set   = (w_rej_evt ? (c_LANE0 << cmd.CMD_LANE) : '0) |
                       (w_abort_evt ? w_lane_vec : '0);

  // A new event in the clearing cycle survives the clear
  always_comb begin
    oor_status_d = (OOR_CLEAR ? '0 : oor_status_q) | w_oor_set;
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      oor_status_q <= '0;
    end else begin
      oor_status_q <= oor_status_d;
    end
  end

  assign OOR_STATUS = oor_status_q;
`endif

endmodule
`default_nettype wire

// File: doc/ddr_iod_delay_tap_ctrl.md
Name: ddr_iod_delay_tap_ctrl

Overview:
- Multi-lane controller for the dynamic delay lines of the DDR PHY IOD blocks.
- Accepts one tap command at a time and converts it into correctly spaced LOAD/MOVE/DIRECTION pulses on the selected lane.
- Keeps a shadow tap count per lane and flags out-of-range conditions.
- Sits between the PHY training logic and the per-pin IOD wrappers; replaces ad-hoc per-pin delay strobing.

Parameters:
- NUM_LANES, 8, number of IOD delay lines controlled; LANE_W = max(1, clog2(NUM_LANES)) is derived.
- TAP_BITS, 7, width of the shadow tap counter and CMD_TAP.
- MAX_TAP, 127, highest legal tap value; must be <= 2^TAP_BITS-1.
- SETTLE_CYCLES, 4, idle FAB_CLK cycles after each MOVE pulse; range 1..255.

Ports:
- FAB_CLK  input  1  controller clock (fabric clock of the IODs)
- ARST  input  1  asynchronous reset, active-high
- CMD_VALID  input  1  command request
- CMD_READY  output  1  controller idle, command accepted when VALID&&READY
- CMD_LANE  input  LANE_W  target lane
- CMD_OP  input  2  00 LOAD (tap:=0), 01 INC, 10 DEC, 11 SET absolute
- CMD_TAP  input  TAP_BITS  target tap for SET; ignored otherwise
- DONE  output  1  one-cycle pulse, command finished
- ERR  output  1  one-cycle pulse coincident with DONE, command hit a boundary or error
- RD_LANE  input  LANE_W  lane selector for readback
- RD_TAP  output  TAP_BITS  shadow tap of RD_LANE, combinational from the registers
- DELAY_LINE_LOAD  output  NUM_LANES  per-lane load strobe
- DELAY_LINE_MOVE  output  NUM_LANES  per-lane move strobe
- DELAY_LINE_DIRECTION  output  NUM_LANES  per-lane direction, 1=increment
- DELAY_LINE_OUT_OF_RANGE  input  NUM_LANES  per-lane out-of-range from IOD

Behaviour:
- One clock, FAB_CLK. ARST is asynchronous, active-high.
- **Reset:** applies at any time, including mid-command.
  - State goes to IDLE. All strobes, DIRECTION, DONE and ERR go to 0. CMD_READY goes to 1. All shadow taps go to 0. Any in-flight command is dropped with no DONE.
  - After reset the hardware tap is unknown, so training issues LOAD per lane first.
- **FSM states:** IDLE, LOAD, MOVE, SETTLE, FIN. CMD_READY is high only in IDLE.
- **Accept:** captures lane, op and target, then moves to the first working state on the next edge.
- **Illegal lane:** CMD_LANE >= NUM_LANES goes IDLE->FIN with ERR and no strobes.
- **LOAD op:** LOAD state drives DELAY_LINE_LOAD[lane]=1 for one cycle, shadow := 0, then goes to SETTLE. After SETTLE it goes to FIN.
- **INC/DEC op:** step count = 1.
  - INC with shadow == MAX_TAP is rejected: go to FIN with ERR, no strobe.
  - DEC with shadow == 0 is rejected the same way.
- **SET op:** first runs a LOAD (LOAD then SETTLE), then does target INC steps.
  - If CMD_TAP > MAX_TAP, target is clamped to MAX_TAP and ERR is flagged at FIN.
  - SET 0 is equivalent to LOAD.
- **MOVE state:** drives DELAY_LINE_MOVE[lane]=1 for exactly one cycle.
  - DELAY_LINE_DIRECTION[lane] is registered one cycle before MOVE and held until the next command.
  - Shadow updates ±1 in the MOVE cycle. Remaining steps decrement.
- **SETTLE state:** lasts exactly SETTLE_CYCLES cycles.
  - On its last cycle DELAY_LINE_OUT_OF_RANGE[lane] is sampled. If high: abort remaining steps, go to FIN with ERR, keep shadow as updated.
  - Otherwise go to MOVE if remaining > 0, else FIN.
- **FIN state:** DONE=1 (plus ERR if flagged) for one cycle, then IDLE. CMD_READY rises the cycle after DONE.
- **Latency:** INC/DEC = 1 (MOVE) + SETTLE_CYCLES + 1 (FIN) cycles from accept to DONE. SET n = (1+S) + n·(1+S) + 1, where S = SETTLE_CYCLES.
- Only the selected lane's strobes ever assert. At most one strobe is high per cycle.

Optional Feature:
- Macro: DDR_TAP_OOR_STATUS_EN.
- **Defined:** adds input OOR_CLEAR (1) and output OOR_STATUS (NUM_LANES).
  - OOR_STATUS[i] is set sticky whenever an out-of-range abort or boundary rejection occurs on lane i.
  - OOR_CLEAR=1 clears all bits next edge; a set in the same cycle wins.
  - Reset value is 0.
- **Undefined:** ports absent; only the ERR pulse reports errors.

Test Plan:
- **Reset then LOAD:** ARST pulse, then LOAD lane 3 -> LOAD[3] high 1 cycle, DONE 5 cycles after MOVE-less SETTLE (S=4), RD_TAP(3)=0, ERR=0.
- **SET:** SET lane 0 tap 10 -> one LOAD pulse, then 10 MOVE pulses with DIRECTION[0]=1, each spaced 5 cycles. DONE at cycle 56 after accept, RD_TAP(0)=10.
- **Boundaries:** DEC on lane at tap 0 -> no strobe, DONE+ERR 1 cycle after accept. INC at tap 127 -> same. SET 200 with TAP_BITS=8, MAX_TAP=127 -> tap=127, ERR.
- **OUT_OF_RANGE abort:** SET lane 1 tap 20, force OUT_OF_RANGE[1]=1 after the 6th MOVE -> abort, RD_TAP(1)=6, DONE+ERR, OOR_STATUS[1]=1 when the macro is enabled.
- **Reset mid-command:** assert ARST during the SETTLE of a SET -> strobes 0 immediately, no DONE, CMD_READY=1, all taps 0.
- **Handshake:** VALID held through a busy period and illegal lane 9 with NUM_LANES=8 -> second command accepted only when READY=1; illegal lane gives DONE+ERR and no strobes.
